// File: rtl/timer_irq_unit.sv
// timer_irq_unit: memory-mapped countdown timer with a level interrupt output.
// Bus reads are combinational; writes and all timer state update on the clock edge.
// Optional feature macro: TIMER_PRESCALE_EN adds a PRESCALE register at offset 3
// and a clock divider that gates the COUNT decrement.
module timer_irq_unit #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_7F00,
   parameter int          PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [1:0] OFF_CTRL     = 2'd0;
   localparam logic [1:0] OFF_PRESET   = 2'd1;
   localparam logic [1:0] OFF_COUNT    = 2'd2;
   localparam logic [1:0] OFF_PRESCALE = 2'd3;

   // CTRL bit positions
   localparam int CTRL_EN = 0;
   localparam int CTRL_IM = 3;

   logic [3:0]  ctrl_q,    ctrl_d;
   logic [31:0] preset_q,  preset_d;
   logic [31:0] count_q,   count_d;
   logic        pending_q, pending_d;
   logic [1:0]  state_q,   state_d;

   logic [1:0]  offset;
   logic        bus_wr;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        tick;
   logic        auto_reload;
   logic        fsm_set_pending;
   logic        fsm_clr_pending;
   logic        fsm_clr_en;

   // Word-aligned decode: the two byte-offset bits select nothing here.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] div_q,      div_d;
   logic                  wr_prescale;
`else
   localparam int unused_prescale_w = PRESCALE_W;
`endif

   // Address decode and write strobes
   assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
   assign offset    = addr[3:2];
   assign bus_wr    = hit && (byteen != 4'b0000);
   assign wr_ctrl   = bus_wr && (offset == OFF_CTRL);
   assign wr_preset = bus_wr && (offset == OFF_PRESET);
`ifdef TIMER_PRESCALE_EN
   assign wr_prescale = bus_wr && (offset == OFF_PRESCALE);
   assign tick        = (div_q == prescale_q);
`else
   assign tick        = 1'b1;
`endif

   // MODE 1 is the only auto-reload encoding; 0, 2 and 3 all behave as one-shot.
   assign auto_reload = (ctrl_q[2:1] == 2'd1);

   // Interrupt is purely register-derived, so no bus-to-irq combinational path.
   assign irq = pending_q & ctrl_q[CTRL_IM];

   // Combinational read mux; everything outside the window reads 0.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      rdata = '0;
      if (hit) begin
         case (offset)
            OFF_CTRL:     rdata = {28'd0, ctrl_q};
            OFF_PRESET:   rdata = preset_q;
            OFF_COUNT:    rdata = count_q;
            OFF_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
               rdata[PRESCALE_W-1:0] = prescale_q;
`else
               rdata = '0;
`endif
            end
            default:      rdata = '0;
         endcase
      end
   end

   // Timer FSM: state, COUNT and divider advance from pre-edge register values.
   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      fsm_set_pending = 1'b0;
      fsm_clr_pending = 1'b0;
      fsm_clr_en      = 1'b0;
`ifdef TIMER_PRESCALE_EN
      div_d           = div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ctrl_q[CTRL_EN]) state_d = S_LOAD;
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
`ifdef TIMER_PRESCALE_EN
            div_d   = '0;
`endif
         end
         S_CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = S_IDLE;
            end else if (count_q == 32'd0) begin
               // Expiry check is not gated by the prescaler tick.
               state_d         = S_INT;
               fsm_set_pending = 1'b1;
            end else if (tick) begin
               count_d = count_q - 32'd1;
`ifdef TIMER_PRESCALE_EN
               div_d   = '0;
`endif
            end else begin
`ifdef TIMER_PRESCALE_EN
               div_d = div_q + 1'b1;
`endif
            end
         end
         S_INT: begin
            if (auto_reload) begin
               // Pending is a one-cycle pulse per expiry in auto-reload mode.
               fsm_clr_pending = 1'b1;
               state_d         = ctrl_q[CTRL_EN] ? S_LOAD : S_IDLE;
            end else begin
               fsm_clr_en = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Register writes and pending flag; CPU write to CTRL beats the FSM's EN clear,
   // and an FSM pending set beats any clear on the same edge.
   always_comb begin
      ctrl_d    = ctrl_q;
      preset_d  = preset_q;
      pending_d = pending_q;
`ifdef TIMER_PRESCALE_EN
      prescale_d = prescale_q;
`endif

      if (fsm_clr_en) ctrl_d[CTRL_EN] = 1'b0;
      if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];

      if (wr_preset) begin
         for (int b = 0; b < 4; b++) begin
            if (byteen[b]) preset_d[8*b +: 8] = wdata[8*b +: 8];
         end
      end

`ifdef TIMER_PRESCALE_EN
      if (wr_prescale) begin
         for (int i = 0; i < PRESCALE_W; i++) begin
            if (byteen[i/8]) prescale_d[i] = wdata[i];
         end
      end
`endif

      if (fsm_set_pending) begin
         pending_d = 1'b1;
      end else if (fsm_clr_pending || wr_ctrl) begin
         pending_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         ctrl_q    <= '0;
         preset_q  <= '0;
         count_q   <= '0;
         pending_q <= 1'b0;
         state_q   <= S_IDLE;
`ifdef TIMER_PRESCALE_EN
         prescale_q <= '0;
         div_q      <= '0;
`endif
      end else begin
         ctrl_q    <= ctrl_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         pending_q <= pending_d;
         state_q   <= state_d;
`ifdef TIMER_PRESCALE_EN
         prescale_q <= prescale_d;
         div_q      <= div_d;
`endif
      end
   end

endmodule

// File: tb/tb_timer_irq_unit.sv
// Directed testbench for timer_irq_unit with hand-computed expectations.
module tb_timer_irq_unit;

   localparam logic [31:0] A_CTRL     = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET   = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT    = 32'h0000_7F08;
   localparam logic [31:0] A_PRESCALE = 32'h0000_7F0C;
   localparam logic [31:0] A_OUTSIDE  = 32'h0000_7F14;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic        hit;
   logic [31:0] rdata;
   logic        irq;

   int n_checks;
   int n_fail;

   timer_irq_unit dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .byteen (byteen),
      .wdata  (wdata),
      .hit    (hit),
      .rdata  (rdata),
      .irq    (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n edges and settle 1ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-edge bus write; returns 1ns after the committing edge.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr   = a;
      wdata  = d;
      byteen = be;
      @(posedge clk);
      #1;
      byteen = 4'b0000;
      wdata  = '0;
   endtask

   // Combinational read, no edge crossed.
   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      addr   = a;
      byteen = 4'b0000;
      #1;
      d = rdata;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      step(1);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      bus_rd(A_CTRL, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h want %h", d, 32'd0); end
      bus_rd(A_PRESET, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_preset: got %h want %h", d, 32'd0); end
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h want %h", d, 32'd0); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_inside: got %b want 1", hit); end
      bus_rd(A_OUTSIDE, d);
      n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_outside: got %b want 0", hit); end
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rdata_outside: got %h want 0", d); end
   endtask

   task automatic test_reset_mid_count();
      logic [31:0] d;
      bus_wr(A_PRESET, 32'd5, 4'hF);
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E0
      step(2);                               // after E2: COUNT = 5
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL midcount_pre: got %h want %h", d, 32'd5); end
      reset = 1'b1;
      #1;
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL async_reset_count: got %h want 0", d); end
      @(posedge clk);
      #2;
      reset = 1'b0;
      step(1);
      bus_rd(A_CTRL, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_ctrl: got %h want 0", d); end
      bus_rd(A_PRESET, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_preset: got %h want 0", d); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq: got %b want 0", irq); end
      // IDLE with EN=0: COUNT must stay 0 and irq low for several cycles.
      step(6);
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL midreset_idle_count: got %h want 0", d); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_idle_irq: got %b want 0", irq); end
   endtask

   task automatic test_byte_merge();
      logic [31:0] d;
      bus_wr(A_PRESET, 32'hFFFF_FFFF, 4'hF);
      bus_wr(A_PRESET, 32'h0000_AB00, 4'b0010);
      bus_rd(A_PRESET, d);
      n_checks++; if (d !== 32'hFFFF_ABFF) begin n_fail++; $display("FAIL preset_merge: got %h want %h", d, 32'hFFFF_ABFF); end
      bus_wr(A_CTRL, 32'hFFFF_FFF4, 4'hF);
      bus_rd(A_CTRL, d);
      n_checks++; if (d !== 32'h0000_0004) begin n_fail++; $display("FAIL ctrl_upper_bits: got %h want %h", d, 32'h4); end
      bus_wr(A_COUNT, 32'h0000_1234, 4'hF);
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL count_readonly: got %h want 0", d); end
      bus_wr(A_CTRL, 32'd0, 4'hF);
   endtask

   task automatic test_one_shot();
      logic [31:0] d;
      logic [31:0] exp_cnt [4];
      exp_cnt[0] = 32'd3; exp_cnt[1] = 32'd2; exp_cnt[2] = 32'd1; exp_cnt[3] = 32'd0;
      bus_wr(A_PRESET, 32'd3, 4'hF);
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E0
      step(1);                               // E1: LOAD
      for (int k = 0; k < 4; k++) begin
         step(1);                            // E2..E5
         bus_rd(A_COUNT, d);
         n_checks++; if (d !== exp_cnt[k]) begin n_fail++; $display("FAIL oneshot_count[%0d]: got %h want %h", k, d, exp_cnt[k]); end
         n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_early_irq[%0d]: got %b want 0", k, irq); end
      end
      step(1);                               // E6
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq: got %b want 1", irq); end
      step(1);                               // E7: EN cleared by FSM
      bus_rd(A_CTRL, d);
      n_checks++; if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL oneshot_ctrl: got %h want %h", d, 32'h8); end
      step(4);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_hold: got %b want 1", irq); end
      bus_wr(A_CTRL, 32'd0, 4'hF);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
      // Re-enable the mask: pending must be truly cleared, not just masked.
      bus_wr(A_CTRL, 32'h0000_0008, 4'hF);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_pending_clear: got %b want 0", irq); end
   endtask

   task automatic test_auto_reload();
      logic [31:0] d;
      logic        exp_irq;
      bus_wr(A_PRESET, 32'd2, 4'hF);
      bus_wr(A_CTRL, 32'h0000_000B, 4'hF);   // E0
      for (int k = 1; k <= 16; k++) begin
         step(1);
         exp_irq = ((k % 5) == 0);
         n_checks++; if (irq !== exp_irq) begin n_fail++; $display("FAIL autoreload_irq[E%0d]: got %b want %b", k, irq, exp_irq); end
      end
      // After E16 the FSM is in LOAD; clearing EN at E17 leaves COUNT=2 frozen.
      bus_wr(A_CTRL, 32'h0000_000A, 4'hF);   // E17
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL autoreload_load: got %h want %h", d, 32'd2); end
      for (int k = 0; k < 10; k++) begin
         step(1);
         n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL autoreload_stopped_irq[%0d]: got %b want 0", k, irq); end
      end
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL autoreload_frozen: got %h want %h", d, 32'd2); end
   endtask

   task automatic test_collision();
      logic [31:0] d;
      // PRESET write during CNT leaves COUNT alone; next reload takes the new value.
      bus_wr(A_PRESET, 32'd4, 4'hF);
      bus_wr(A_CTRL, 32'h0000_0003, 4'hF);   // E0: EN, MODE 1, IM=0
      step(3);                               // E3: COUNT = 3
      bus_wr(A_PRESET, 32'd7, 4'hF);         // E4: COUNT = 2
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL collision_count: got %h want %h", d, 32'd2); end
      bus_rd(A_PRESET, d);
      n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL collision_preset: got %h want %h", d, 32'd7); end
      step(5);                               // E5=1, E6=0, E7 INT, E8 LOAD, E9 COUNT=7
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd7) begin n_fail++; $display("FAIL collision_reload: got %h want %h", d, 32'd7); end
      do_reset();

      // CPU write to CTRL on the INT edge in MODE 0 keeps EN=1.
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E0, PRESET=0
      step(3);                               // E3: INT
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collision_int_irq: got %b want 1", irq); end
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E4
      bus_rd(A_CTRL, d);
      n_checks++; if (d !== 32'h0000_0009) begin n_fail++; $display("FAIL collision_cpu_wins: got %h want %h", d, 32'h9); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL collision_write_clears: got %b want 0", irq); end
      step(2);                               // E5 LOAD, E6 CNT with COUNT=0
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E7: set and clear together
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collision_set_wins: got %b want 1", irq); end
      do_reset();
   endtask

   task automatic test_prescale();
      logic [31:0] d;
`ifdef TIMER_PRESCALE_EN
      bus_wr(A_PRESCALE, 32'hFFFF_FF03, 4'hF);
      bus_rd(A_PRESCALE, d);
      n_checks++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL prescale_readback: got %h want %h", d, 32'h3); end
      bus_wr(A_PRESET, 32'd2, 4'hF);
      bus_wr(A_CTRL, 32'h0000_0009, 4'hF);   // E0
      step(2);                               // E2: COUNT = 2
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL prescale_load: got %h want %h", d, 32'd2); end
      step(3);                               // E5: still 2
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL prescale_hold: got %h want %h", d, 32'd2); end
      step(1);                               // E6: 1
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL prescale_tick1: got %h want %h", d, 32'd1); end
      step(4);                               // E10: 0
      bus_rd(A_COUNT, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL prescale_tick2: got %h want 0", d); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL prescale_early_irq: got %b want 0", irq); end
      step(1);                               // E11
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL prescale_irq: got %b want 1", irq); end
`else
      bus_wr(A_PRESCALE, 32'hFFFF_FFFF, 4'hF);
      bus_rd(A_PRESCALE, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL offset3_reserved: got %h want 0", d); end
`endif
      do_reset();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      addr     = A_CTRL;
      byteen   = 4'b0000;
      wdata    = '0;
      step(2);
      reset = 1'b0;
      step(1);

      test_reset();
      test_reset_mid_count();
      test_byte_merge();
      test_one_shot();
      do_reset();
      test_auto_reload();
      do_reset();
      test_collision();
      test_prescale();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
